ldl_crc32_dn_append: RTL

//  Ethernet FCS generator/appender, NUM bytes per beat, MSB-first byte lanes.

---
 rtl/ldl_crc32_dn_append.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ldl_crc32_dn_append.sv
// Ethernet FCS appender: passes frame beats through with one cycle of latency and
// appends the 4 CRC-32 bytes after the last payload byte, adding beats when needed.
module ldl_crc32_dn_append #(
  parameter int unsigned NUM = 4,
  parameter int unsigned BW  = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [8*NUM-1:0]  in_data,
  input  logic [BW-1:0]     in_bnum,
  input  logic              in_valid,
  input  logic              in_eof,
  output logic              in_ready,
  output logic [8*NUM-1:0]  out_data,
  output logic [BW-1:0]     out_bnum,
  output logic              out_valid,
  output logic              out_eof
);

  localparam int unsigned DW       = 8 * NUM;
  localparam int unsigned RW       = 3;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY_REF = 32'hEDB8_8320;

  typedef enum logic {
    PASS = 1'b0,
    TAIL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     fcs_q, fcs_d;
  logic [RW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   out_data_d;
  logic [BW-1:0]   out_bnum_d;
  logic            out_valid_d;
  logic            out_eof_d;
  logic            in_ready_d;

  logic [31:0]     crc_acc;
  logic [31:0]     fcs_now;
  int unsigned     k;
  int unsigned     rem;
  int unsigned     idx;

  // One byte of reflected CRC-32, data bits consumed LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned n = 0; n < 8; n++) begin
      r = r[0] ? ((r >> 1) ^ POLY_REF) : (r >> 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PASS;
      crc_q     <= CRC_INIT;
      fcs_q     <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      out_data  <= '0;
      out_bnum  <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      fcs_q     <= fcs_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      out_data  <= out_data_d;
      out_bnum  <= out_bnum_d;
      out_valid <= out_valid_d;
      out_eof   <= out_eof_d;
      in_ready  <= in_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    fcs_d       = fcs_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    out_data_d  = '0;
    out_bnum_d  = '0;
    out_valid_d = 1'b0;
    out_eof_d   = 1'b0;
    crc_acc     = crc_q;
    fcs_now     = '0;
    k           = NUM;
    rem         = 32'(rem_q);
    idx         = 32'(idx_q);

    unique case (state_q)
      PASS: begin
        if (in_valid) begin
          if (in_eof) begin
            k = 32'(in_bnum);
            if (k == 0 || k > NUM) k = NUM;
          end
          for (int unsigned i = 0; i < NUM; i++) begin
            if (i < k) crc_acc = crc_step(crc_acc, in_data[8*(NUM-1-i) +: 8]);
          end
          out_valid_d = 1'b1;
          if (!in_eof) begin
            out_data_d = in_data;
            crc_d      = crc_acc;
          end else begin
            // FCS bytes follow the last payload byte, low byte first.
            fcs_now = ~crc_acc;
            crc_d   = CRC_INIT;
            for (int unsigned i = 0; i < NUM; i++) begin
              if (i < k) begin
                out_data_d[8*(NUM-1-i) +: 8] = in_data[8*(NUM-1-i) +: 8];
              end else if (i - k < 4) begin
                out_data_d[8*(NUM-1-i) +: 8] = fcs_now[8*(i-k) +: 8];
              end
            end
            if (k + 4 <= NUM) begin
              out_eof_d  = 1'b1;
              out_bnum_d = BW'((k + 4) % NUM);
            end else begin
              state_d = TAIL;
              fcs_d   = fcs_now;
              rem_d   = RW'(k + 4 - NUM);
              idx_d   = RW'(NUM - k);
            end
          end
        end
      end

      TAIL: begin
        out_valid_d = 1'b1;
        for (int unsigned i = 0; i < NUM; i++) begin
          if (i < rem && idx + i < 4) begin
            out_data_d[8*(NUM-1-i) +: 8] = fcs_q[8*(idx+i) +: 8];
          end
        end
        if (rem <= NUM) begin
          out_eof_d  = 1'b1;
          out_bnum_d = BW'(rem % NUM);
          state_d    = PASS;
          rem_d      = '0;
          idx_d      = '0;
        end else begin
          rem_d = RW'(rem - NUM);
          idx_d = RW'(idx + NUM);
        end
      end

      default: state_d = PASS;
    endcase

    in_ready_d = (state_d == PASS);
  end

endmodule
